// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with one-entry skid buffer, synchronous flush and transfer counter.
// Latency 1 cycle; in_ready/out_valid decode only the state register, so a stall reaches upstream one edge later.
module pipe_stage_skid #(
  parameter int WIDTH  = 32,
  parameter int NCH    = 4,
  parameter int FWIDTH = 4,
  parameter int CNTW   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [FWIDTH-1:0]    in_flags,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [WIDTH-1:0]     out_flags,
  output logic [1:0]           occ,
  output logic [CNTW-1:0]      xfer_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

  state_t               state;
  logic [NCH*WIDTH-1:0] skid_data;
  logic [WIDTH-1:0]     skid_flags;
  logic [WIDTH-1:0]     flags_ext;
  logic                 acc;
  logic                 take;

  always_comb begin
    flags_ext = '0;
    flags_ext[FWIDTH-1:0] = in_flags;
  end

  assign in_ready  = (state != SKID);
  assign out_valid = (state != EMPTY);
  assign occ       = (state == SKID) ? 2'd2 : ((state == FULL) ? 2'd1 : 2'd0);
  assign acc       = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_flags  <= '0;
      skid_data  <= '0;
      skid_flags <= '0;
      xfer_cnt   <= '0;
    end else begin
      // A take in a flush cycle still completed on the wire, so it is counted.
      if (take) xfer_cnt <= xfer_cnt + CNTW'(1);
      if (flush) begin
        state      <= EMPTY;
        out_data   <= '0;
        out_flags  <= '0;
        skid_data  <= '0;
        skid_flags <= '0;
      end else begin
        case (state)
          EMPTY: begin
            if (acc) begin
              state     <= FULL;
              out_data  <= in_data;
              out_flags <= flags_ext;
            end
          end
          FULL: begin
            if (acc && take) begin
              out_data  <= in_data;
              out_flags <= flags_ext;
            end else if (acc) begin
              state      <= SKID;
              skid_data  <= in_data;
              skid_flags <= flags_ext;
            end else if (take) begin
              state <= EMPTY;
            end
          end
          SKID: begin
            if (take) begin
              state     <= FULL;
              out_data  <= skid_data;
              out_flags <= skid_flags;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random-backpressure checks for pipe_stage_skid (CNTW=4 so counter wrap is reachable).
module tb_pipe_stage_skid;
  localparam int WIDTH  = 32;
  localparam int NCH    = 4;
  localparam int FWIDTH = 4;
  localparam int CNTW   = 4;
  localparam int DW     = NCH * WIDTH;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [DW-1:0]     in_data, out_data;
  logic [FWIDTH-1:0] in_flags;
  logic [WIDTH-1:0]  out_flags;
  logic [1:0]        occ;
  logic [CNTW-1:0]   xfer_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_skid #(.WIDTH(WIDTH), .NCH(NCH), .FWIDTH(FWIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .occ(occ), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input int w);
    logic [DW-1:0] d;
    d = '0;
    for (int k = 0; k < NCH; k++) d[k*WIDTH +: WIDTH] = WIDTH'(w * 16 + k);
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_flags = '0;
    #2;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occ !== 2'd0) begin n_fail++; $display("FAIL reset_ctrl: out_valid=%b in_ready=%b occ=%0d, want 0 1 0", out_valid, in_ready, occ); end
    n_tests++; if (out_data !== '0 || out_flags !== '0 || xfer_cnt !== '0) begin n_fail++; $display("FAIL reset_dat: data=%h flags=%h cnt=%0d, want zeros", out_data, out_flags, xfer_cnt); end
    step();
    reset = 1'b1;
    in_valid = 1'b1; in_data = mk(1); in_flags = 4'h3; out_ready = 1'b1;
    step();
    in_data = mk(2);
    step();
    in_data = mk(3); out_ready = 1'b0;
    step();
    n_tests++; if (occ !== 2'd2 || xfer_cnt !== 4'd1) begin n_fail++; $display("FAIL reset_prefill: occ=%0d cnt=%0d, want 2 1", occ, xfer_cnt); end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occ !== 2'd0 || xfer_cnt !== '0) begin n_fail++; $display("FAIL reset_async: out_valid=%b in_ready=%b occ=%0d cnt=%0d, want 0 1 0 0", out_valid, in_ready, occ, xfer_cnt); end
    n_tests++; if (out_data !== '0 || out_flags !== '0) begin n_fail++; $display("FAIL reset_async_dat: data=%h flags=%h, want 0", out_data, out_flags); end
    #2 reset = 1'b1;
    step();
    n_tests++; if (out_valid !== 1'b0 || occ !== 2'd0 || xfer_cnt !== '0 || out_data !== '0) begin n_fail++; $display("FAIL idle: out_valid=%b occ=%0d cnt=%0d data=%h, want 0 0 0 0", out_valid, occ, xfer_cnt, out_data); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; in_flags = 4'hA;
    for (int w = 1; w <= 8; w++) begin
      in_valid = 1'b1; in_data = mk(w);
      step();
      n_tests++; if (out_valid !== 1'b1 || out_data !== mk(w) || out_flags !== 32'h0000000A || occ !== 2'd1) begin n_fail++; $display("FAIL stream_w%0d: valid=%b data=%h flags=%h occ=%0d, want 1 %h 0000000a 1", w, out_valid, out_data, out_flags, occ, mk(w)); end
    end
    in_valid = 1'b0;
    step();
    n_tests++; if (xfer_cnt !== 4'd8 || occ !== 2'd0) begin n_fail++; $display("FAIL stream_end: cnt=%0d occ=%0d, want 8 0", xfer_cnt, occ); end
  endtask

  task automatic test_skid();
    in_valid = 1'b1; in_data = mk(20); in_flags = 4'h1; out_ready = 1'b0;
    step();
    n_tests++; if (out_data !== mk(20) || in_ready !== 1'b1 || occ !== 2'd1) begin n_fail++; $display("FAIL skid_a: data=%h in_ready=%b occ=%0d, want A 1 1", out_data, in_ready, occ); end
    in_data = mk(21); in_flags = 4'h2;
    step();
    n_tests++; if (out_data !== mk(20) || in_ready !== 1'b0 || occ !== 2'd2) begin n_fail++; $display("FAIL skid_b: data=%h in_ready=%b occ=%0d, want A 0 2", out_data, in_ready, occ); end
    in_data = mk(22); in_flags = 4'h3;
    step();
    n_tests++; if (out_data !== mk(20) || out_flags !== 32'h1 || in_ready !== 1'b0 || occ !== 2'd2) begin n_fail++; $display("FAIL skid_hold: data=%h flags=%h in_ready=%b occ=%0d, want A 1 0 2", out_data, out_flags, in_ready, occ); end
    out_ready = 1'b1;
    step();
    n_tests++; if (out_data !== mk(21) || out_flags !== 32'h2 || in_ready !== 1'b1 || occ !== 2'd1) begin n_fail++; $display("FAIL skid_rec: data=%h flags=%h in_ready=%b occ=%0d, want B 2 1 1", out_data, out_flags, in_ready, occ); end
    step();
    n_tests++; if (out_data !== mk(22) || out_flags !== 32'h3 || occ !== 2'd1) begin n_fail++; $display("FAIL skid_c: data=%h flags=%h occ=%0d, want C 3 1", out_data, out_flags, occ); end
    in_valid = 1'b0;
    step();
    n_tests++; if (occ !== 2'd0 || xfer_cnt !== 4'd11) begin n_fail++; $display("FAIL skid_end: occ=%0d cnt=%0d, want 0 11", occ, xfer_cnt); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1; in_data = mk(30); in_flags = 4'h5; out_ready = 1'b0;
    step();
    in_data = mk(31);
    step();
    n_tests++; if (occ !== 2'd2) begin n_fail++; $display("FAIL flush_pre: occ=%0d, want 2", occ); end
    flush = 1'b1; in_data = mk(32); out_ready = 1'b1;
    step();
    n_tests++; if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== '0 || out_flags !== '0 || xfer_cnt !== 4'd12) begin n_fail++; $display("FAIL flush: occ=%0d valid=%b data=%h flags=%h cnt=%0d, want 0 0 0 0 12", occ, out_valid, out_data, out_flags, xfer_cnt); end
    flush = 1'b0; in_valid = 1'b0;
    step();
    n_tests++; if (out_valid !== 1'b0 || occ !== 2'd0 || xfer_cnt !== 4'd12) begin n_fail++; $display("FAIL flush_discard: valid=%b occ=%0d cnt=%0d, want 0 0 12", out_valid, occ, xfer_cnt); end
  endtask

  task automatic test_wrap();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    out_ready = 1'b1; in_flags = 4'h0;
    for (int i = 1; i <= 18; i++) begin
      in_valid = (i <= 17); in_data = mk(i);
      step();
      if (i == 16) begin n_tests++; if (xfer_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap15: cnt=%0d, want 15", xfer_cnt); end end
      if (i == 17) begin n_tests++; if (xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap16: cnt=%0d, want 0", xfer_cnt); end end
      if (i == 18) begin n_tests++; if (xfer_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap17: cnt=%0d, want 1", xfer_cnt); end end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [DW-1:0]    qd[$];
    logic [WIDTH-1:0] qf[$];
    logic [DW-1:0]    held_d;
    logic [WIDTH-1:0] held_f;
    logic             acc, take, stall;
    int               sc;
    int               bad;
    sc = 0;
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = $urandom;
      in_flags = FWIDTH'($urandom);
      acc   = in_valid && in_ready;
      take  = out_valid && out_ready;
      stall = out_valid && !out_ready;
      held_d = out_data; held_f = out_flags;
      bad = 0;
      if (int'(occ) != qd.size() || in_ready !== (qd.size() != 2) || out_valid !== (qd.size() != 0)) bad = 1;
      else if (out_valid && (out_data !== qd[0] || out_flags !== qf[0])) bad = 1;
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rand_c%0d: occ=%0d valid=%b data=%h, want occ %0d data %h", c, occ, out_valid, out_data, qd.size(), (qd.size() != 0) ? qd[0] : '0); end
      if (acc) begin qd.push_back(in_data); qf.push_back(WIDTH'(in_flags)); end
      step();
      if (take) begin void'(qd.pop_front()); void'(qf.pop_front()); sc++; end
      if (stall) begin
        n_tests++; if (out_data !== held_d || out_flags !== held_f) begin n_fail++; $display("FAIL rand_stable_c%0d: data=%h, want %h", c, out_data, held_d); end
      end
    end
    n_tests++; if (xfer_cnt !== CNTW'(sc)) begin n_fail++; $display("FAIL rand_cnt: cnt=%0d, want %0d", xfer_cnt, sc % 16); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register carrying NCH data channels of WIDTH bits plus a narrow flag field, with valid/ready handshaking, a one-entry skid buffer, synchronous flush and a transfer counter. It sits between datapath stages, such as decode→execute, where a downstream stall must hold the stage without losing data. It registers all outputs, and no combinational path runs from inputs to outputs or from out_ready to in_ready.

## Interface
- WIDTH, 32, width of each data channel and of out_flags
- NCH, 4, number of data channels packed in in_data/out_data (channel k at bits [k*WIDTH +: WIDTH])
- FWIDTH, 4, width of in_flags (must be ≤ WIDTH)
- CNTW, 16, width of xfer_cnt
- clk  in  1  clock, all state changes on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- flush  in  1  synchronous flush, highest priority after reset
- in_valid  in  1  upstream offers in_data/in_flags
- in_ready  out  1  stage can accept this cycle
- in_data  in  NCH*WIDTH  packed channel data
- in_flags  in  FWIDTH  flag field (e.g. condition/ALU flags)
- out_valid  out  1  out_data/out_flags valid
- out_ready  in  1  downstream takes output this cycle
- out_data  out  NCH*WIDTH  registered channel data
- out_flags  out  WIDTH  in_flags zero-extended to WIDTH
- occ  out  2  entries held: 0, 1 or 2
- xfer_cnt  out  CNTW  count of completed output transfers

## Operation
- Storage: main register (drives outputs) and skid register, each holding data plus flags.
- States: EMPTY (occ=0), FULL (main valid, occ=1), SKID (both valid, occ=2).
- acc = in_valid & in_ready; take = out_valid & out_ready.
- in_ready = (state != SKID); out_valid = (state != EMPTY); both decode only the state register.
- EMPTY: acc → FULL, main ← input. Otherwise hold.
- FULL: acc & take → FULL, main ← input. acc & !take → SKID, skid ← input. !acc & take → EMPTY. Neither → hold.
- SKID: in_ready=0, so acc is impossible. take → FULL, main ← skid. Otherwise hold.
- Flags zero-extend on capture: out_flags[FWIDTH-1:0] = captured flags, upper bits 0.
- Flush: next state EMPTY, main and skid data/flags ← 0. Any acc in the flush cycle is discarded. A take in the flush cycle counts toward xfer_cnt, because the output was valid that cycle.
- xfer_cnt increments by 1 on every take and wraps from 2^CNTW−1 to 0. Flush does not clear it.
- While out_valid=1 and out_ready=0, out_data/out_flags stay stable until take.

## Timing
- Reset asserted (reset=0), asynchronously: state EMPTY, out_valid=0, in_ready=1, out_data=0, out_flags=0, occ=0, xfer_cnt=0. No capture while reset=0.
- Reset mid-operation: contents are lost immediately, with no wait for a clock edge.
- Latency: data accepted at edge N appears on out_data with out_valid=1 after edge N.
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- After a stall starts (out_ready=0 while FULL and acc), in_ready drops at the next edge. The skid register absorbs the one in-flight word.
- Recovery: the first take from SKID reasserts in_ready after that edge.
- Simultaneous events: flush overrides acc and take for state and data. Reset overrides everything.
- Order is preserved: main always holds the older word, skid the newer.

## Test plan
- Reset/idle: hold reset=0 mid-stream with occ=2 → outputs immediately 0, in_ready=1, xfer_cnt=0. Release, then one cycle with in_valid=0 → no change.
- Streaming: NCH=4, send words 1..8 (channel k = word*16+k, in_flags=0xA) with out_ready=1 → out_data matches one cycle later, out_flags=0x0000000A, xfer_cnt=8, occ never 2.
- Stall/skid: send A, B, C back-to-back; out_ready=0 from the cycle after A. Required: A held on out_data, B captured in skid, occ=2, in_ready=0, C held upstream. Then out_ready=1 → outputs A, B, C in order, no loss or duplication.
- Flush: occ=2, assert flush with in_valid=1 and out_ready=1 → next cycle occ=0, out_valid=0, out_data=0, input discarded, xfer_cnt incremented by 1.
- Counter wrap: CNTW=4, 17 transfers → xfer_cnt reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
- Random back-pressure: random in_valid/out_ready for 10k cycles → scoreboard shows in-order, lossless delivery; output is stable while stalled; xfer_cnt equals the scoreboard count mod 2^CNTW.
